deck_shuffle_dealer: RTL and testbench
======================================

Name: deck_shuffle_dealer

Overview:
Owns the 52-card deck storage and sequences it for the blackjack game controller. On command it initialises the deck, shuffles it in place (Fisher-Yates, 6-bit LFSR with rejection sampling), then serves one card per request through a single-cycle request/valid handshake. It sits between the game controller (requester) and the card/sum display datapath, and decodes each card to rank, suit and blackjack point value.

Parameters:
DECK_SIZE, 52, number of cards; card ids 0..DECK_SIZE-1; fixed 52 for rank/suit decode
LFSR_SEED, 6'b011110, LFSR load value on reset; must be nonzero
LOW_THRESH, 15, low_deck asserts when cards_left < LOW_THRESH

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-low reset
shuffle_start  in  1  one-cycle pulse: init and shuffle the deck
card_req  in  1  one-cycle pulse: deal next card
busy  out  1  high during INIT and SHUFFLE
shuffle_done  out  1  one-cycle pulse on entry to READY
card_valid  out  1  one-cycle pulse, card outputs valid
card_id  out  6  dealt card id 0..51
card_rank  out  4  1..13 (1=ace, 11..13=J,Q,K)
card_suit  out  2  0..3
card_points  out  4  ace=1, 2..10 face, J/Q/K=10
cards_left  out  6  undealt cards 0..52
low_deck  out  1  cards_left < LOW_THRESH
empty_err  out  1  one-cycle pulse: request refused, deck empty

Behaviour:
- Reset (rst==0 at clk edge): state IDLE, lfsr=LFSR_SEED, deal ptr=0, cards_left=0, all outputs 0 except low_deck=1. Deck contents undefined until first INIT. Reset wins over all inputs, including mid-INIT or mid-SHUFFLE.
- LFSR: 6-bit Fibonacci, x^6+x^5+1, shifts left every cycle out of reset (free-running, period 63); new bit = lfsr[5]^lfsr[4].
- States: IDLE, INIT, SHUFFLE, READY.
- IDLE/READY + shuffle_start -> INIT. shuffle_start ignored in INIT/SHUFFLE.
- INIT: counter k=0..51, writes deck[k]=k one per cycle; 52 cycles; then SHUFFLE with i=51.
- SHUFFLE: each cycle j=lfsr-1 (0..62). If j<=i: swap deck[i], deck[j] in that cycle (j==i is a legal no-op swap), i=i-1. Else retry next cycle. After the swap at i=1 -> READY, cards_left=52, ptr=0, shuffle_done pulses the same cycle READY is entered. Duration is deterministic for a given seed and start cycle; bounded by 51*63 cycles.
- busy=1 throughout INIT and SHUFFLE; card_req there -> dropped, no card_valid, no empty_err.
- READY + card_req, cards_left>0: next cycle card_valid=1, card_id=deck[ptr], decoded fields valid, ptr+1, cards_left-1. Latency 1 cycle; back-to-back requests give back-to-back valids.
- READY + card_req, cards_left==0: next cycle empty_err=1, card_valid=0.
- IDLE + card_req: empty_err pulse (cards_left==0).
- shuffle_start and card_req in the same READY cycle: shuffle wins, request dropped.
- Decode: suit=card_id/13, rank=card_id-13*suit+1, by compare/subtract only, no divider. points = (rank>=10) ? 10 : rank.
- Card outputs hold their last value when card_valid=0.

Optional Feature:
AUTO_RESHUFFLE_EN: when defined, a card_req with cards_left==0 in READY does not pulse empty_err. It latches a pending request, enters INIT/SHUFFLE, and on reaching READY serves the pending card (card_valid one cycle after shuffle_done). When undefined, the request is refused with an empty_err pulse.

Test Plan:
- Reset held 3 cycles, release -> busy=0, cards_left=0, low_deck=1, card_valid=0; card_req -> empty_err pulse next cycle.
- shuffle_start after reset with seed 6'b011110 -> busy high exactly 52 cycles of INIT plus the SHUFFLE duration from the golden model; shuffle_done pulse; cards_left=52, low_deck=0.
- 52 consecutive card_req -> 52 consecutive card_valid; ids a permutation of 0..51 matching the model; low_deck rises when cards_left=14; 53rd req -> empty_err (AUTO_RESHUFFLE_EN undefined).
- Decode checks: card_id 12 -> rank 13, suit 0, points 10; card_id 13 -> rank 1, suit 1, points 1; card_id 51 -> rank 13, suit 3; card_id 8 -> rank 9, points 9.
- rst low mid-SHUFFLE, then shuffle_start at the same cycle offset after release -> identical sequence to a fresh run; shuffle_start+card_req together in READY -> no card_valid, busy next cycle.
- AUTO_RESHUFFLE_EN defined: deal 52, then card_req -> no empty_err, busy, shuffle_done, card_valid one cycle later with cards_left=51.

Source files
------------

// File: rtl/deck_shuffle_dealer.sv
// 52-card deck store: INIT, in-place Fisher-Yates shuffle driven by a 6-bit LFSR, one card per request.
// Optional: define AUTO_RESHUFFLE_EN to reshuffle and serve a request that arrives on an empty deck.
module deck_shuffle_dealer #(
   parameter int unsigned DECK_SIZE  = 52,
   parameter logic [5:0]  LFSR_SEED  = 6'b011110,
   parameter int unsigned LOW_THRESH = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       shuffle_start,
   input  logic       card_req,
   output logic       busy,
   output logic       shuffle_done,
   output logic       card_valid,
   output logic [5:0] card_id,
   output logic [3:0] card_rank,
   output logic [1:0] card_suit,
   output logic [3:0] card_points,
   output logic [5:0] cards_left,
   output logic       low_deck,
   output logic       empty_err
);

   typedef enum logic [1:0] {S_IDLE, S_INIT, S_SHUFFLE, S_READY} state_t;

   state_t     state_q, state_d;
   logic [5:0] lfsr_q, lfsr_d;
   logic [5:0] idx_q, idx_d;
   logic [5:0] ptr_q, ptr_d;
   logic [5:0] left_q, left_d;
   logic [5:0] deck_q [DECK_SIZE];
   logic [5:0] deck_d [DECK_SIZE];
   logic       shuffle_done_q, shuffle_done_d;
   logic       card_valid_q, card_valid_d;
   logic       empty_err_q, empty_err_d;
   logic [5:0] card_id_q, card_id_d;
   logic [3:0] card_rank_q, card_rank_d;
   logic [1:0] card_suit_q, card_suit_d;
   logic [3:0] card_points_q, card_points_d;
   logic       req_eff;
`ifdef AUTO_RESHUFFLE_EN
   logic       pending_q, pending_d;
`endif

   logic [5:0] swap_j;
   logic [5:0] head_id;
   logic [3:0] head_off;
   logic [1:0] head_suit;
   logic [3:0] head_rank;
   logic [3:0] head_points;

   assign swap_j  = lfsr_q - 6'd1;
   assign head_id = deck_q[(ptr_q < 6'(DECK_SIZE)) ? ptr_q : 6'd0];
`ifdef AUTO_RESHUFFLE_EN
   assign req_eff = card_req | pending_q;
`else
   assign req_eff = card_req;
`endif

   // Suit/rank by range compare and constant subtract instead of a divider.
   always_comb begin
      head_suit = 2'd0;
      head_off  = head_id[3:0];
      if (head_id >= 6'd39) begin
         head_suit = 2'd3;
         head_off  = 4'(head_id - 6'd39);
      end else if (head_id >= 6'd26) begin
         head_suit = 2'd2;
         head_off  = 4'(head_id - 6'd26);
      end else if (head_id >= 6'd13) begin
         head_suit = 2'd1;
         head_off  = 4'(head_id - 6'd13);
      end
      head_rank   = head_off + 4'd1;
      head_points = (head_rank >= 4'd10) ? 4'd10 : head_rank;
   end

   always_comb begin
      state_d        = state_q;
      lfsr_d         = {lfsr_q[4:0], lfsr_q[5] ^ lfsr_q[4]};
      idx_d          = idx_q;
      ptr_d          = ptr_q;
      left_d         = left_q;
      deck_d         = deck_q;
      shuffle_done_d = 1'b0;
      card_valid_d   = 1'b0;
      empty_err_d    = 1'b0;
      card_id_d      = card_id_q;
      card_rank_d    = card_rank_q;
      card_suit_d    = card_suit_q;
      card_points_d  = card_points_q;
`ifdef AUTO_RESHUFFLE_EN
      pending_d      = pending_q;
`endif
      unique case (state_q)
         // idx counts up through INIT (k) and down through SHUFFLE (i).
         S_INIT: begin
            deck_d[idx_q] = idx_q;
            if (idx_q == 6'(DECK_SIZE - 1)) begin
               state_d = S_SHUFFLE;
            end else begin
               idx_d = idx_q + 6'd1;
            end
         end
         S_SHUFFLE: begin
            if (swap_j <= idx_q) begin
               deck_d[idx_q]  = deck_q[swap_j];
               deck_d[swap_j] = deck_q[idx_q];
               if (idx_q == 6'd1) begin
                  state_d        = S_READY;
                  left_d         = 6'(DECK_SIZE);
                  ptr_d          = '0;
                  shuffle_done_d = 1'b1;
               end else begin
                  idx_d = idx_q - 6'd1;
               end
            end
         end
         default: begin
            if (shuffle_start) begin
               state_d = S_INIT;
               idx_d   = '0;
               ptr_d   = '0;
               left_d  = '0;
            end else if (req_eff) begin
               if (state_q == S_READY && left_q != '0) begin
                  card_valid_d  = 1'b1;
                  card_id_d     = head_id;
                  card_rank_d   = head_rank;
                  card_suit_d   = head_suit;
                  card_points_d = head_points;
                  ptr_d         = ptr_q + 6'd1;
                  left_d        = left_q - 6'd1;
`ifdef AUTO_RESHUFFLE_EN
                  pending_d     = 1'b0;
               end else if (state_q == S_READY) begin
                  pending_d = 1'b1;
                  state_d   = S_INIT;
                  idx_d     = '0;
                  ptr_d     = '0;
`endif
               end else begin
                  empty_err_d = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q        <= S_IDLE;
         lfsr_q         <= LFSR_SEED;
         idx_q          <= '0;
         ptr_q          <= '0;
         left_q         <= '0;
         shuffle_done_q <= 1'b0;
         card_valid_q   <= 1'b0;
         empty_err_q    <= 1'b0;
         card_id_q      <= '0;
         card_rank_q    <= '0;
         card_suit_q    <= '0;
         card_points_q  <= '0;
`ifdef AUTO_RESHUFFLE_EN
         pending_q      <= 1'b0;
`endif
      end else begin
         state_q        <= state_d;
         lfsr_q         <= lfsr_d;
         idx_q          <= idx_d;
         ptr_q          <= ptr_d;
         left_q         <= left_d;
         shuffle_done_q <= shuffle_done_d;
         card_valid_q   <= card_valid_d;
         empty_err_q    <= empty_err_d;
         card_id_q      <= card_id_d;
         card_rank_q    <= card_rank_d;
         card_suit_q    <= card_suit_d;
         card_points_q  <= card_points_d;
`ifdef AUTO_RESHUFFLE_EN
         pending_q      <= pending_d;
`endif
      end
   end

   // Deck contents are undefined until the first INIT, so no reset here.
   always_ff @(posedge clk) begin
      deck_q <= deck_d;
   end

   assign busy         = (state_q == S_INIT) || (state_q == S_SHUFFLE);
   assign shuffle_done = shuffle_done_q;
   assign card_valid   = card_valid_q;
   assign card_id      = card_id_q;
   assign card_rank    = card_rank_q;
   assign card_suit    = card_suit_q;
   assign card_points  = card_points_q;
   assign cards_left   = left_q;
   assign low_deck     = left_q < 6'(LOW_THRESH);
   assign empty_err    = empty_err_q;

endmodule

// File: tb/tb_deck_shuffle_dealer.sv
// Self-checking bench for deck_shuffle_dealer against an array-based Fisher-Yates reference.
module tb_deck_shuffle_dealer;
   localparam logic [5:0] SEED = 6'b011110;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       shuffle_start = 1'b0;
   logic       card_req = 1'b0;
   logic       busy, shuffle_done, card_valid, low_deck, empty_err;
   logic [5:0] card_id, cards_left;
   logic [3:0] card_rank, card_points;
   logic [1:0] card_suit;

   int unsigned passed = 0;
   int unsigned total = 0;
   int unsigned edge_cnt = 0;
   logic [5:0]  lfsr_tab [63];
   int          model_deck [52];
   int          first_deck [52];
   int          got [52];
   int          model_cycles;

   deck_shuffle_dealer #(.DECK_SIZE(52), .LFSR_SEED(SEED), .LOW_THRESH(15)) dut (
      .clk(clk), .rst(rst), .shuffle_start(shuffle_start), .card_req(card_req),
      .busy(busy), .shuffle_done(shuffle_done), .card_valid(card_valid),
      .card_id(card_id), .card_rank(card_rank), .card_suit(card_suit),
      .card_points(card_points), .cards_left(cards_left), .low_deck(low_deck),
      .empty_err(empty_err)
   );

   always #5 clk = ~clk;

   // Index of the next rising edge since reset release (the LFSR has shifted that many times).
   always @(posedge clk) begin
      if (!rst) edge_cnt <= 0;
      else      edge_cnt <= edge_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Shuffle outcome for a shuffle_start sampled at edge index n_s.
   task automatic build_model(input int unsigned n_s);
      int i, j, tmp;
      int unsigned n;
      for (int k = 0; k < 52; k++) model_deck[k] = k;
      i = 51;
      n = n_s + 53;
      model_cycles = 0;
      while (i >= 1) begin
         j = int'(lfsr_tab[n % 63]) - 1;
         if (j <= i) begin
            tmp = model_deck[i];
            model_deck[i] = model_deck[j];
            model_deck[j] = tmp;
            i--;
         end
         n++;
         model_cycles++;
      end
   endtask

   task automatic reset_and_probe();
      rst = 1'b0;
      shuffle_start = 1'b0;
      card_req = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_cards_left", cards_left, 0);
      chk("rst_low_deck", low_deck, 1);
      chk("rst_card_valid", card_valid, 0);
      chk("rst_shuffle_done", shuffle_done, 0);
      chk("rst_empty_err", empty_err, 0);
      rst = 1'b1;
      @(negedge clk);
      chk("idle_busy", busy, 0);
      card_req = 1'b1;
      @(negedge clk);
      card_req = 1'b0;
      chk("idle_empty_err", empty_err, 1);
      chk("idle_no_valid", card_valid, 0);
      @(negedge clk);
      chk("idle_empty_err_pulse", empty_err, 0);
   endtask

   task automatic wait_shuffle();
      int unsigned cnt;
      cnt = 0;
      while (busy === 1'b1 && cnt < 4000) begin
         cnt++;
         @(negedge clk);
      end
      chk("busy_cycles", cnt, 52 + model_cycles);
      chk("shuffle_done", shuffle_done, 1);
      chk("ready_cards_left", cards_left, 52);
      chk("ready_low_deck", low_deck, 0);
   endtask

   task automatic run_shuffle(input bit with_req);
      @(negedge clk);
      shuffle_start = 1'b1;
      card_req = with_req;
      build_model(edge_cnt);
      @(negedge clk);
      shuffle_start = 1'b0;
      card_req = 1'b0;
      if (with_req) chk("start_req_no_valid", card_valid, 0);
      chk("start_busy", busy, 1);
      wait_shuffle();
      @(negedge clk);
      chk("shuffle_done_pulse", shuffle_done, 0);
   endtask

   task automatic deal_all(input bit gaps);
      bit          prev;
      int unsigned served;
      logic [63:0] seen;
      int          id, rank;
      prev = 1'b0;
      served = 0;
      seen = '0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (prev) begin
            id = model_deck[served];
            rank = id % 13 + 1;
            chk("card_valid", card_valid, 1);
            chk("card_id", card_id, id);
            chk("card_rank", card_rank, rank);
            chk("card_suit", card_suit, id / 13);
            chk("card_points", card_points, (rank >= 10) ? 10 : rank);
            chk("cards_left", cards_left, 51 - served);
            chk("low_deck", low_deck, (51 - int'(served)) < 15);
            got[served] = int'(card_id);
            seen[card_id] = 1'b1;
            served++;
         end else begin
            chk("valid_low", card_valid, 0);
         end
         if (served == 52) break;
         prev = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         card_req = prev;
      end
      card_req = 1'b0;
      chk("deal_count", served, 52);
      chk("distinct_ids", $countones(seen), 52);
   endtask

   initial begin
      lfsr_tab[0] = SEED;
      for (int k = 1; k < 63; k++)
         lfsr_tab[k] = {lfsr_tab[k-1][4:0], lfsr_tab[k-1][5] ^ lfsr_tab[k-1][4]};

      reset_and_probe();
      run_shuffle(1'b0);
      deal_all(1'b0);
      for (int k = 0; k < 52; k++) first_deck[k] = got[k];

`ifdef AUTO_RESHUFFLE_EN
      @(negedge clk);
      card_req = 1'b1;
      build_model(edge_cnt);
      @(negedge clk);
      card_req = 1'b0;
      chk("auto_no_empty_err", empty_err, 0);
      chk("auto_busy", busy, 1);
      wait_shuffle();
      @(negedge clk);
      chk("auto_card_valid", card_valid, 1);
      chk("auto_card_id", card_id, model_deck[0]);
      chk("auto_cards_left", cards_left, 51);
`else
      @(negedge clk);
      card_req = 1'b1;
      @(negedge clk);
      card_req = 1'b0;
      chk("empty_err_53", empty_err, 1);
      chk("empty_no_valid", card_valid, 0);
      chk("empty_cards_left", cards_left, 0);
`endif

      // Shuffle request colliding with a card request in READY.
      run_shuffle(1'b1);
      deal_all(1'b1);

      // Reset in mid-shuffle, then repeat the first run's timing.
      @(negedge clk);
      shuffle_start = 1'b1;
      @(negedge clk);
      shuffle_start = 1'b0;
      repeat (59) @(negedge clk);
      chk("mid_shuffle_busy", busy, 1);
      reset_and_probe();
      run_shuffle(1'b0);
      deal_all(1'b0);
      for (int k = 0; k < 52; k++) chk("repeat_seq", got[k], first_deck[k]);

      // Shuffle from a random LFSR phase.
      repeat ($urandom_range(0, 70)) @(negedge clk);
      run_shuffle(1'b0);
      deal_all(1'b1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end
endmodule
